// File: rtl/fc_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : fc_mem_responder_if
// Brief   : Read (AR/R) and write (AW/W/B) burst bus between FC initiators and memory.
// Revision: 1.0
// ============================================================================
interface fc_mem_responder_if #(
    parameter int WORD_LEN = 32,
    parameter int ID_W     = 4
);
    logic [27:0]           araddr;
    logic [3:0]            arlen;
    logic [ID_W-1:0]       arid;
    logic                  arap;
    logic                  arvalid;
    logic                  arready;
    logic [WORD_LEN-1:0]   rdata;
    logic [ID_W-1:0]       rid;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    logic [27:0]           awaddr;
    logic [3:0]            awlen;
    logic [ID_W-1:0]       awid;
    logic                  awap;
    logic                  awvalid;
    logic                  awready;
    logic [WORD_LEN-1:0]   wdata;
    logic [WORD_LEN/8-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [ID_W-1:0]       bid;
    logic                  bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arlen, arid, arap, arvalid, rready,
        output awaddr, awlen, awid, awap, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  arready, rdata, rid, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  araddr, arlen, arid, arap, arvalid, rready,
        input  awaddr, awlen, awid, awap, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output arready, rdata, rid, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );
endinterface
`default_nettype wire

// File: rtl/fc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : fc_mem_responder
// Brief   : Burst memory target with independent read and write channels.
// Revision: 1.0
// ============================================================================
module fc_mem_responder #(
    parameter int WORD_LEN   = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int ID_W       = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    fc_mem_responder_if.slave bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int NBYTE = WORD_LEN / 8;

    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;

    logic [WORD_LEN-1:0]   mem_q [DEPTH];
    logic                  up_q;
    rstate_t               rstate_q, rstate_d;
    logic [DEPTH_LOG2-1:0] raddr_q;
    logic [3:0]            rlen_q, rbeat_q;
    logic [ID_W-1:0]       rid_q;
    logic [WORD_LEN-1:0]   rdata_q;
    wstate_t               wstate_q, wstate_d;
    logic [DEPTH_LOG2-1:0] waddr_q;
    logic [3:0]            wlen_q, wbeat_q;
    logic [ID_W-1:0]       wid_q;
    logic                  bresp_q;

    logic ar_hs, r_hs, r_last, aw_hs, w_hs, w_end, b_hs;
    logic w_unused;

    assign w_unused = ^{bus.arap, bus.awap, bus.araddr[27:DEPTH_LOG2], bus.awaddr[27:DEPTH_LOG2]};

    // up_q holds both address channels off until the first edge after reset release
    assign bus.arready = up_q && (rstate_q == R_IDLE);
    assign bus.rvalid  = (rstate_q == R_DATA);
    assign r_last      = (rbeat_q == rlen_q);
    assign bus.rlast   = bus.rvalid && r_last;
    assign bus.rdata   = rdata_q;
    assign bus.rid     = rid_q;
    assign ar_hs       = bus.arvalid && bus.arready;
    assign r_hs        = bus.rvalid && bus.rready;

    assign bus.awready = up_q && (wstate_q == W_IDLE);
    assign bus.wready  = (wstate_q == W_DATA);
    assign bus.bvalid  = (wstate_q == W_RESP);
    assign bus.bid     = wid_q;
    assign bus.bresp   = bresp_q;
    assign aw_hs       = bus.awvalid && bus.awready;
    assign w_hs        = bus.wvalid && bus.wready;
    assign w_end       = w_hs && (bus.wlast || (wbeat_q == wlen_q));
    assign b_hs        = bus.bvalid && bus.bready;

    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_DATA;
            R_DATA:  if (r_hs && r_last) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE:  if (aw_hs) wstate_d = W_DATA;
            W_DATA:  if (w_end) wstate_d = W_RESP;
            W_RESP:  if (b_hs) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    // The next word is fetched on each accepted beat, so the read stream has no bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q     <= 1'b0;
            rstate_q <= R_IDLE;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rbeat_q  <= '0;
            rid_q    <= '0;
            rdata_q  <= '0;
        end else begin
            up_q     <= 1'b1;
            rstate_q <= rstate_d;
            if (ar_hs) begin
                rdata_q <= mem_q[bus.araddr[DEPTH_LOG2-1:0]];
                raddr_q <= bus.araddr[DEPTH_LOG2-1:0] + DEPTH_LOG2'(1);
                rlen_q  <= bus.arlen;
                rbeat_q <= '0;
                rid_q   <= bus.arid;
            end else if (r_hs && !r_last) begin
                rdata_q <= mem_q[raddr_q];
                raddr_q <= raddr_q + DEPTH_LOG2'(1);
                rbeat_q <= rbeat_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q <= W_IDLE;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wbeat_q  <= '0;
            wid_q    <= '0;
            bresp_q  <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            if (aw_hs) begin
                waddr_q <= bus.awaddr[DEPTH_LOG2-1:0];
                wlen_q  <= bus.awlen;
                wbeat_q <= '0;
                wid_q   <= bus.awid;
            end else if (w_hs) begin
                waddr_q <= waddr_q + DEPTH_LOG2'(1);
                wbeat_q <= wbeat_q + 4'd1;
            end
            // Error when wlast and the programmed length disagree on the final beat
            if (w_end) begin
                bresp_q <= bus.wlast ^ (wbeat_q == wlen_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (bus.wstrb[b]) begin
                    mem_q[waddr_q][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end
endmodule
`default_nettype wire
